// File: rtl/pacman_pixel_gen.sv
// Pac-man pixel generator: maze border, sprite motion FSM and mouth animation,
// producing a registered 12-bit RGB stream aligned to the sync block's p_tick.
module pacman_pixel_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SPRITE      = 16,
    parameter int unsigned WALL        = 8,
    parameter int unsigned STEP        = 2,
    parameter int unsigned ANIM_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [3:0]  btn,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic [9:0]  pac_x,
    output logic [9:0]  pac_y
);

    localparam int unsigned AW = (ANIM_FRAMES > 2) ? $clog2(ANIM_FRAMES) : 1;

    localparam logic [9:0] X_MIN   = 10'(WALL);
    localparam logic [9:0] Y_MIN   = 10'(WALL);
    localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - WALL - SPRITE);
    localparam logic [9:0] Y_MAX   = 10'(V_ACTIVE - WALL - SPRITE);
    localparam logic [9:0] X_RST   = 10'((H_ACTIVE - SPRITE) / 2);
    localparam logic [9:0] Y_RST   = 10'((V_ACTIVE - SPRITE) / 2);
    localparam logic [9:0] D_STEP  = 10'(STEP);
    localparam logic [9:0] HALF    = 10'(SPRITE / 2);
    localparam logic [9:0] M_LO    = 10'(SPRITE / 2 - 2);
    localparam logic [9:0] M_HI    = 10'(SPRITE / 2 + 1);
    localparam logic [9:0] SPR     = 10'(SPRITE);
    localparam logic [9:0] X_WALL  = 10'(H_ACTIVE - WALL);
    localparam logic [9:0] Y_WALL  = 10'(V_ACTIVE - WALL);
    localparam logic [9:0] Y_TICK  = 10'(V_ACTIVE + 1);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_FRAMES - 1);
    localparam logic [AW-1:0] ANIM_HALF = AW'(ANIM_FRAMES / 2);

    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_YELLOW = 12'hFF0;
    localparam logic [11:0] COL_BLUE   = 12'h00F;

    typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;
    typedef enum logic [1:0] {StMoving, StBlocked, StPaused} state_e;

    state_e          state_q, state_d;
    dir_e            dir_q, dir_d;
    dir_e            blk_dir_q, blk_dir_d;
    dir_e            dir_new;
    logic [9:0]      pac_x_q, pac_x_d;
    logic [9:0]      pac_y_q, pac_y_d;
    logic [AW-1:0]   anim_q, anim_d;
    logic [AW-1:0]   anim_inc;
    logic            frame_tick_q;
    logic            frame_tick_d;
    logic [11:0]     rgb_q, rgb_d;

    logic [9:0]      mv_x, mv_y;
    logic            hit;

    // ------------------------------------------------------------------
    // Frame tick: one clk after the sync block reaches pixel (0, V_ACTIVE+1)
    // ------------------------------------------------------------------
    assign frame_tick_d = p_tick && (pixel_x == 10'd0) && (pixel_y == Y_TICK);

    // ------------------------------------------------------------------
    // Direction latch, priority up > down > left > right
    // ------------------------------------------------------------------
    always_comb begin
        dir_new = dir_q;
        if (!pause) begin
            if (btn[3])      dir_new = DirUp;
            else if (btn[2]) dir_new = DirDown;
            else if (btn[1]) dir_new = DirLeft;
            else if (btn[0]) dir_new = DirRight;
        end
    end

    // Candidate position after one STEP along dir_new, clamped to the walls
    always_comb begin
        mv_x = pac_x_q;
        mv_y = pac_y_q;
        hit  = 1'b0;
        unique case (dir_new)
            DirRight: begin
                if ((11'(pac_x_q) + 11'(STEP)) >= 11'(X_MAX)) mv_x = X_MAX;
                else                                            mv_x = pac_x_q + D_STEP;
                hit = (mv_x == X_MAX);
            end
            DirLeft: begin
                if (pac_x_q < (X_MIN + D_STEP)) mv_x = X_MIN;
                else                             mv_x = pac_x_q - D_STEP;
                hit = (mv_x == X_MIN);
            end
            DirDown: begin
                if ((11'(pac_y_q) + 11'(STEP)) >= 11'(Y_MAX)) mv_y = Y_MAX;
                else                                            mv_y = pac_y_q + D_STEP;
                hit = (mv_y == Y_MAX);
            end
            DirUp: begin
                if (pac_y_q < (Y_MIN + D_STEP)) mv_y = Y_MIN;
                else                             mv_y = pac_y_q - D_STEP;
                hit = (mv_y == Y_MIN);
            end
        endcase
    end

    assign anim_inc = (anim_q == ANIM_LAST) ? '0 : anim_q + 1'b1;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StMoving;
            dir_q        <= DirRight;
            blk_dir_q    <= DirRight;
            pac_x_q      <= X_RST;
            pac_y_q      <= Y_RST;
            anim_q       <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            blk_dir_q    <= blk_dir_d;
            pac_x_q      <= pac_x_d;
            pac_y_q      <= pac_y_d;
            anim_q       <= anim_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (frame_tick_q) begin
            if (pause) begin
                state_d = StPaused;
            end else begin
                case (state_q)
                    StPaused:  state_d = StMoving;
                    StMoving:  state_d = hit ? StBlocked : StMoving;
                    StBlocked: begin
                        // Any direction other than the one that hit the wall frees the sprite
                        if (dir_new != blk_dir_q) state_d = hit ? StBlocked : StMoving;
                    end
                    default:   state_d = StMoving;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (position, direction, animation)
    // ------------------------------------------------------------------
    always_comb begin
        dir_d     = dir_q;
        blk_dir_d = blk_dir_q;
        pac_x_d   = pac_x_q;
        pac_y_d   = pac_y_q;
        anim_d    = anim_q;
        if (frame_tick_q) begin
            dir_d = dir_new;
            if (!pause) begin
                case (state_q)
                    StMoving: begin
                        pac_x_d   = mv_x;
                        pac_y_d   = mv_y;
                        anim_d    = anim_inc;
                        blk_dir_d = dir_new;
                    end
                    StBlocked: begin
                        if (dir_new != blk_dir_q) begin
                            pac_x_d   = mv_x;
                            pac_y_d   = mv_y;
                            anim_d    = anim_inc;
                            blk_dir_d = dir_new;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic signed [10:0] lx, ly;
    logic [9:0]         lxu, lyu;
    logic               in_box, in_mouth, mouth_open, in_wall;

    assign lx  = $signed(11'(pixel_x) - 11'(pac_x_q));
    assign ly  = $signed(11'(pixel_y) - 11'(pac_y_q));
    assign lxu = lx[9:0];
    assign lyu = ly[9:0];

    assign in_box     = !lx[10] && !ly[10] && (lxu < SPR) && (lyu < SPR);
    assign mouth_open = (anim_q >= ANIM_HALF);
    assign in_wall    = (pixel_x < X_MIN) || (pixel_x >= X_WALL) ||
                        (pixel_y < Y_MIN) || (pixel_y >= Y_WALL);

    always_comb begin
        in_mouth = 1'b0;
        unique case (dir_q)
            DirRight: in_mouth = (lxu >= HALF) && (lyu >= M_LO) && (lyu <= M_HI);
            DirLeft:  in_mouth = (lxu <  HALF) && (lyu >= M_LO) && (lyu <= M_HI);
            DirUp:    in_mouth = (lyu <  HALF) && (lxu >= M_LO) && (lxu <= M_HI);
            DirDown:  in_mouth = (lyu >= HALF) && (lxu >= M_LO) && (lxu <= M_HI);
        endcase
    end

    always_comb begin
        rgb_d = COL_BLACK;
        if (!video_on)                 rgb_d = COL_BLACK;
        else if (in_box)               rgb_d = (in_mouth && mouth_open) ? COL_BLACK : COL_YELLOW;
        else if (in_wall)              rgb_d = COL_BLUE;
        else                           rgb_d = COL_BLACK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       rgb_q <= COL_BLACK;
        else if (p_tick) rgb_q <= rgb_d;
    end

    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;
    assign pac_x      = pac_x_q;
    assign pac_y      = pac_y_q;

endmodule

// File: tb/tb_pacman_pixel_gen.sv
// Directed bench for pacman_pixel_gen: pixel coordinates and frame ticks are
// driven directly rather than through a full sync generator.
module tb_pacman_pixel_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [3:0]  btn;
    logic        pause;
    logic [11:0] rgb;
    logic        frame_tick;
    logic [9:0]  pac_x;
    logic [9:0]  pac_y;

    int nvec   = 0;
    int nerr   = 0;
    int pulses = 0;

    pacman_pixel_gen dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .btn        (btn),
        .pause      (pause),
        .rgb        (rgb),
        .frame_tick (frame_tick),
        .pac_x      (pac_x),
        .pac_y      (pac_y)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_tick) pulses++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame tick; optionally verifies the pulse is exactly one clk wide
    task automatic do_frame(input bit chk);
        @(negedge clk);
        p_tick  = 1'b1;
        pixel_x = 10'd0;
        pixel_y = 10'd481;
        @(negedge clk);
        p_tick  = 1'b0;
        pixel_y = 10'd0;
        if (chk) check_eq("ft_high", 32'(frame_tick), 32'd1);
        @(negedge clk);
        if (chk) check_eq("ft_low", 32'(frame_tick), 32'd0);
    endtask

    task automatic frames(input int n, input bit chk);
        for (int i = 0; i < n; i++) do_frame(chk);
    endtask

    task automatic pix_check(input string tag, input int x, input int y, input bit vo,
                             input logic [11:0] exp);
        @(negedge clk);
        p_tick   = 1'b1;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = vo;
        @(negedge clk);
        p_tick   = 1'b0;
        video_on = 1'b1;
        check_eq(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic pos_check(input string tag, input int x, input int y);
        check_eq({tag, "_x"}, 32'(pac_x), 32'(x));
        check_eq({tag, "_y"}, 32'(pac_y), 32'(y));
    endtask

    initial begin
        int p0;
        reset    = 1'b1;
        p_tick   = 1'b0;
        video_on = 1'b1;
        pixel_x  = 10'd100;
        pixel_y  = 10'd100;
        btn      = 4'b0000;
        pause    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        pos_check("rst", 312, 232);
        check_eq("rst_rgb", 32'(rgb), 32'h000);
        check_eq("rst_ft", 32'(frame_tick), 32'd0);
        check_eq("rst_anim", 32'(dut.anim_q), 32'd0);

        // Pixel colours at the centre, dir RIGHT, mouth closed
        pix_check("pix_centre", 320, 240, 1'b1, 12'hFF0);
        pix_check("pix_wall_l", 2, 100, 1'b1, 12'h00F);
        pix_check("pix_floor", 100, 100, 1'b1, 12'h000);
        pix_check("pix_blank", 320, 240, 1'b0, 12'h000);
        pix_check("pix_spr_org", 312, 232, 1'b1, 12'hFF0);
        pix_check("pix_spr_last", 327, 240, 1'b1, 12'hFF0);
        pix_check("pix_spr_past", 328, 240, 1'b1, 12'h000);
        pix_check("pix_spr_neg", 311, 240, 1'b1, 12'h000);
        pix_check("pix_wall_r_in", 631, 100, 1'b1, 12'h000);
        pix_check("pix_wall_r", 632, 100, 1'b1, 12'h00F);
        pix_check("pix_wall_b_in", 100, 471, 1'b1, 12'h000);
        pix_check("pix_wall_b", 100, 472, 1'b1, 12'h00F);
        pix_check("pix_corner", 639, 479, 1'b1, 12'h00F);

        // Frame tick decode boundaries
        @(negedge clk); p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
        @(negedge clk); p_tick = 1'b0;
        check_eq("ft_y480", 32'(frame_tick), 32'd0);
        @(negedge clk); pixel_y = 10'd481;
        @(negedge clk);
        check_eq("ft_no_ptick", 32'(frame_tick), 32'd0);
        @(negedge clk); p_tick = 1'b1; pixel_x = 10'd1;
        @(negedge clk); p_tick = 1'b0;
        check_eq("ft_x1", 32'(frame_tick), 32'd0);
        pos_check("no_tick_pos", 312, 232);

        // Move a little, light a wall pixel, then reset mid-frame
        frames(3, 1'b0);
        pos_check("pre_rst", 318, 232);
        pix_check("pre_rst_rgb", 2, 100, 1'b1, 12'h00F);
        @(negedge clk); pixel_x = 10'd100;
        @(negedge clk);
        check_eq("rgb_hold", 32'(rgb), 32'h00F);
        #2 reset = 1'b1;
        #1 check_eq("mid_rst_rgb", 32'(rgb), 32'h000);
        pos_check("mid_rst", 312, 232);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ft", 32'(frame_tick), 32'd0);

        // Ten frames with no buttons: keeps moving right
        p0 = pulses;
        frames(10, 1'b1);
        pos_check("ten", 332, 232);
        check_eq("ten_anim", 32'(dut.anim_q), 32'd2);
        check_eq("ten_pulses", 32'(pulses - p0), 32'd10);

        // Mouth animation threshold
        frames(1, 1'b0);
        pos_check("anim3", 334, 232);
        pix_check("mouth_shut", 346, 240, 1'b1, 12'hFF0);
        frames(1, 1'b0);
        pos_check("anim4", 336, 232);
        check_eq("anim4_val", 32'(dut.anim_q), 32'd4);
        pix_check("mouth_open", 348, 240, 1'b1, 12'h000);
        pix_check("mouth_body", 340, 240, 1'b1, 12'hFF0);

        // Pause with btn=down: everything frozen, dir stays RIGHT
        pause = 1'b1;
        btn   = 4'b0100;
        frames(5, 1'b0);
        pos_check("paused", 336, 232);
        check_eq("paused_anim", 32'(dut.anim_q), 32'd4);
        pix_check("paused_dir", 348, 240, 1'b1, 12'h000);
        pause = 1'b0;
        btn   = 4'b0000;
        frames(1, 1'b0);
        pos_check("unpause", 336, 232);
        check_eq("unpause_anim", 32'(dut.anim_q), 32'd4);
        frames(1, 1'b0);
        pos_check("resume", 338, 232);
        check_eq("resume_anim", 32'(dut.anim_q), 32'd5);

        // Run into the right wall from the centre
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        btn = 4'b0001;
        frames(152, 1'b0);
        pos_check("at_wall", 616, 232);
        check_eq("at_wall_anim", 32'(dut.anim_q), 32'd0);
        frames(5, 1'b0);
        pos_check("blocked", 616, 232);
        check_eq("blocked_anim", 32'(dut.anim_q), 32'd0);
        btn = 4'b0010;
        frames(1, 1'b0);
        pos_check("unblock", 614, 232);
        frames(1, 1'b0);
        pos_check("moving_l", 612, 232);

        // Up beats left; then drive into the top wall
        btn = 4'b1010;
        frames(1, 1'b0);
        pos_check("up_prio", 612, 230);
        btn = 4'b0000;
        frames(1, 1'b0);
        pos_check("up_keep", 612, 228);
        frames(110, 1'b0);
        pos_check("top_wall", 612, 8);
        frames(1, 1'b0);
        pos_check("top_hold", 612, 8);
        btn = 4'b0100;
        frames(1, 1'b0);
        pos_check("top_leave", 612, 10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
